// File: rtl/if_stage_if.sv
// Instruction-cache request/ready handshake between the fetch stage and the icache.
interface if_stage_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_rdata;

    modport master (output icache_req, output icache_addr,
                    input  icache_ready, input icache_rdata);
    modport slave  (input  icache_req, input icache_addr,
                    output icache_ready, output icache_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, icache handshake, skid buffer and IF/ID register.
// Define BTB_EN to build the direct-mapped branch target buffer; otherwise pred = pc+4.
//
// state   | meaning
// REQ     | request outstanding at pc (idle for the first cycle after reset)
// HOLD    | fetched word parked in the skid buffer while decode is stalled
// DISCARD | finishing an access issued before a redirect; its data is dropped
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        memhazard,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    if_stage_if.master  ic,
    output logic [31:0] pcD,
    output logic [31:0] instrD,
    output logic [31:0] predictpcD,
    output logic        validD
);
    localparam int          IDX_W = $clog2(BTB_ENTRIES);
    localparam int          TAG_W = 30 - IDX_W;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {REQ, HOLD, DISCARD} state_t;

    state_t           state;
    logic             req_q;
    logic [31:0]      pc;
    logic [31:0]      redir_pc;
    logic [31:0]      pred;
    logic [31:0]      skid_pc;
    logic [31:0]      skid_instr;
    logic [31:0]      skid_pred;
    logic             stall;
    logic             rdy;
    logic [IDX_W-1:0] lk_idx;

    assign stall          = hazard | memhazard;
    assign rdy            = ic.icache_ready & req_q;
    assign ic.icache_req  = req_q;
    assign ic.icache_addr = pc;
    assign lk_idx         = pc[IDX_W+1:2];

`ifdef BTB_EN
    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];
    logic [IDX_W-1:0]       up_idx;
    logic                   up_hit;
    logic                   unused_btb;

    assign up_idx     = upd_pc[IDX_W+1:2];
    assign up_hit     = btb_valid[up_idx] && (btb_tag[up_idx] == upd_pc[31:IDX_W+2]);
    assign pred       = (btb_valid[lk_idx] && (btb_tag[lk_idx] == pc[31:IDX_W+2]) &&
                         btb_ctr[lk_idx][1]) ? btb_target[lk_idx] : pc + 32'd4;
    assign unused_btb = ^upd_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_ctr[i[IDX_W-1:0]] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    btb_target[up_idx] <= upd_target;
                    if (btb_ctr[up_idx] != 2'b11) btb_ctr[up_idx] <= btb_ctr[up_idx] + 2'd1;
                end else if (btb_ctr[up_idx] != 2'b00) begin
                    btb_ctr[up_idx] <= btb_ctr[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid[up_idx]  <= 1'b1;
                btb_tag[up_idx]    <= upd_pc[31:IDX_W+2];
                btb_target[up_idx] <= upd_target;
                btb_ctr[up_idx]    <= 2'b10;
            end
        end
    end
`else
    logic unused_upd;

    assign pred       = pc + 32'd4;
    assign unused_upd = ^{lk_idx, upd_valid, upd_pc, upd_target, upd_taken};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            req_q      <= 1'b0;
            pc         <= RESET_PC;
            redir_pc   <= '0;
            skid_pc    <= '0;
            skid_instr <= NOP;
            skid_pred  <= '0;
            pcD        <= '0;
            instrD     <= NOP;
            predictpcD <= '0;
            validD     <= 1'b0;
        end else if (redirect) begin
            pcD        <= pc;
            instrD     <= NOP;
            predictpcD <= pc;
            validD     <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP;
            skid_pred  <= '0;
            // An access still in flight must finish on its old address first.
            if (state != HOLD && req_q && !rdy) begin
                state    <= DISCARD;
                redir_pc <= redirect_pc;
            end else begin
                state <= REQ;
                req_q <= 1'b1;
                pc    <= redirect_pc;
            end
        end else begin
            case (state)
                REQ: begin
                    req_q <= 1'b1;
                    if (rdy) begin
                        pc <= pred;
                        if (stall) begin
                            skid_pc    <= pc;
                            skid_instr <= ic.icache_rdata;
                            skid_pred  <= pred;
                            state      <= HOLD;
                            req_q      <= 1'b0;
                        end else begin
                            pcD        <= pc;
                            instrD     <= ic.icache_rdata;
                            predictpcD <= pred;
                            validD     <= 1'b1;
                        end
                    end else if (!stall) begin
                        pcD        <= pc;
                        instrD     <= NOP;
                        predictpcD <= pc;
                        validD     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pcD        <= skid_pc;
                        instrD     <= skid_instr;
                        predictpcD <= skid_pred;
                        validD     <= 1'b1;
                        state      <= REQ;
                        req_q      <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (!stall) begin
                        pcD        <= pc;
                        instrD     <= NOP;
                        predictpcD <= pc;
                        validD     <= 1'b0;
                    end
                    if (rdy) begin
                        pc    <= redir_pc;
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: icache responder, transaction-level fetch model, directed + random phases.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          N   = 16;
    localparam int          IW  = 4;
`ifdef BTB_EN
    localparam logic [31:0] P80 = 32'h80;
`else
    localparam logic [31:0] P80 = 32'h24;
`endif

    logic        clk = 1'b0;
    logic        rst, hazard, memhazard, redirect, upd_valid, upd_taken, validD;
    logic [31:0] redirect_pc, upd_pc, upd_target, pcD, instrD, predictpcD;

    if_stage_if ic();

    if_stage #(.RESET_PC(32'h0), .BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .hazard(hazard), .memhazard(memhazard),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .ic(ic),
        .pcD(pcD), .instrD(instrD), .predictpcD(predictpcD), .validD(validD)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    // stimulus knobs
    logic        d_rst = 1'b1, d_hz = 1'b0, d_mh = 1'b0, d_rd = 1'b0, d_uv = 1'b0, d_ut = 1'b0;
    logic [31:0] d_rpc = '0, d_upc = '0, d_utg = '0;
    bit          rand_mode = 1'b0;
    int          lat_mode = 0;

    // icache responder
    bit          busy = 1'b0;
    int          wl = 0;
    logic [31:0] busy_addr = '0;
    logic        rdy;

    // fetch model
    logic [31:0] exp_pcD = '0, exp_instr = NOP, exp_pred = '0, exp_pc = '0;
    logic        exp_valid = 1'b0;
    bit          exp_known = 1'b1;
    bit          pend_v = 1'b0;
    logic [31:0] pend_pc, pend_instr, pend_pred;
    bit          poisoned = 1'b0;
    bit          prev_rst = 1'b1;

    logic [31:0] o_pcD, o_instr, o_pred, o_addr;
    logic        o_valid, o_req;

`ifdef BTB_EN
    bit          mb_v   [N];
    logic [31:0] mb_tag [N];
    logic [31:0] mb_tg  [N];
    int          mb_ctr [N];
`endif

    function automatic logic [31:0] mpred(input logic [31:0] a);
`ifdef BTB_EN
        int i;
        i = int'((a >> 2) % 32'(N));
        if (mb_v[i] && mb_tag[i] == (a >> (IW + 2)) && mb_ctr[i] >= 2) return mb_tg[i];
`endif
        return a + 32'd4;
    endfunction

    task automatic model_btb(input bit reset);
`ifdef BTB_EN
        int i;
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                mb_v[k] = 1'b0;
                mb_ctr[k] = 1;
            end
        end else if (d_uv) begin
            i = int'((d_upc >> 2) % 32'(N));
            if (mb_v[i] && mb_tag[i] == (d_upc >> (IW + 2))) begin
                if (d_ut) begin
                    if (mb_ctr[i] < 3) mb_ctr[i]++;
                    mb_tg[i] = d_utg;
                end else if (mb_ctr[i] > 0) begin
                    mb_ctr[i]--;
                end
            end else if (d_ut) begin
                mb_v[i] = 1'b1;
                mb_tag[i] = d_upc >> (IW + 2);
                mb_tg[i] = d_utg;
                mb_ctr[i] = 2;
            end
        end
`endif
    endtask

    task automatic set_bubble();
        exp_valid = 1'b0;
        exp_instr = NOP;
        exp_known = 1'b0;
    endtask

    task automatic cycle();
        bit stall;
        @(negedge clk);
        o_pcD = pcD; o_instr = instrD; o_pred = predictpcD; o_valid = validD;
        o_req = ic.icache_req; o_addr = ic.icache_addr;
        chk("validD", {31'b0, o_valid}, {31'b0, exp_valid});
        chk("instrD", o_instr, exp_instr);
        if (exp_known) begin
            chk("pcD", o_pcD, exp_pcD);
            chk("predictpcD", o_pred, exp_pred);
        end
        if (prev_rst) chk("req_in_reset", {31'b0, o_req}, 32'd0);
        if (busy) begin
            chk("req_held", {31'b0, o_req}, 32'd1);
            chk("addr_stable", o_addr, busy_addr);
        end

        if (rand_mode) begin
            d_rst = ($urandom_range(0, 199) == 0);
            d_hz  = ($urandom_range(0, 9) == 0);
            d_mh  = ($urandom_range(0, 9) == 0);
            d_rd  = ($urandom_range(0, 14) == 0);
            d_rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 63)) << 2);
            d_uv  = ($urandom_range(0, 3) == 0);
            d_upc = 32'($urandom_range(0, 63)) << 2;
            d_utg = 32'($urandom_range(0, 63)) << 2;
            d_ut  = ($urandom_range(0, 2) != 0);
        end
        rst = d_rst; hazard = d_hz; memhazard = d_mh; redirect = d_rd; redirect_pc = d_rpc;
        upd_valid = d_uv; upd_pc = d_upc; upd_target = d_utg; upd_taken = d_ut;

        rdy = 1'b0;
        if (d_rst) begin
            busy = 1'b0;
        end else begin
            if (!busy && o_req) begin
                busy = 1'b1;
                busy_addr = o_addr;
                wl = (lat_mode == 0) ? 0 : (lat_mode == 1) ? 3 : int'($urandom_range(0, 3));
            end
            if (busy) begin
                if (wl == 0) begin
                    rdy = 1'b1;
                    busy = 1'b0;
                end else begin
                    wl--;
                end
            end
        end
        ic.icache_ready = rdy;
        ic.icache_rdata = rdy ? mem(busy_addr) : 32'hDEAD_BEEF;

        stall = d_hz | d_mh;
        if (d_rst) begin
            exp_pcD = '0; exp_instr = NOP; exp_pred = '0; exp_valid = 1'b0; exp_known = 1'b1;
            pend_v = 1'b0; poisoned = 1'b0; exp_pc = 32'h0;
        end else if (d_rd) begin
            set_bubble();
            pend_v = 1'b0;
            exp_pc = d_rpc;
            poisoned = busy;
        end else if (rdy && !poisoned) begin
            chk("fetch_addr", busy_addr, exp_pc);
            exp_pc = mpred(busy_addr);
            if (!stall) begin
                exp_pcD = busy_addr; exp_instr = mem(busy_addr); exp_pred = exp_pc;
                exp_valid = 1'b1; exp_known = 1'b1;
            end else begin
                pend_v = 1'b1; pend_pc = busy_addr; pend_instr = mem(busy_addr); pend_pred = exp_pc;
            end
        end else if (rdy) begin
            poisoned = 1'b0;
            if (!stall) set_bubble();
        end else if (pend_v && !stall) begin
            exp_pcD = pend_pc; exp_instr = pend_instr; exp_pred = pend_pred;
            exp_valid = 1'b1; exp_known = 1'b1;
            pend_v = 1'b0;
        end else if (!stall) begin
            set_bubble();
        end
        model_btb(d_rst);
        prev_rst = d_rst;
    endtask

    task automatic do_reset();
        d_rst = 1'b1; d_hz = 1'b0; d_mh = 1'b0; d_rd = 1'b0; d_uv = 1'b0; d_ut = 1'b0;
        d_rpc = '0; d_upc = '0; d_utg = '0;
        repeat (3) cycle();
        d_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hazard = 1'b0; memhazard = 1'b0; redirect = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
        ic.icache_ready = 1'b0; ic.icache_rdata = '0;
        model_btb(1'b1);

        // zero-wait sequential stream
        lat_mode = 0;
        do_reset();
        cycle();
        chk("rst_pcD", o_pcD, 32'h0);
        chk("rst_instrD", o_instr, NOP);
        chk("rst_validD", {31'b0, o_valid}, 32'd0);
        cycle();
        chk("first_req", {31'b0, o_req}, 32'd1);
        chk("first_addr", o_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("seq_pcD", o_pcD, 32'(k * 4));
            chk("seq_validD", {31'b0, o_valid}, 32'd1);
        end

        // load-use stall for two cycles with the word parked in the skid buffer
        do_reset();
        cycle(); cycle();
        d_hz = 1'b1;
        cycle(); chk("stall_c", o_pcD, 32'h0);
        cycle(); chk("stall_d", o_pcD, 32'h0); chk("hold_req", {31'b0, o_req}, 32'd0);
        d_hz = 1'b0;
        cycle(); chk("stall_e", o_pcD, 32'h0);
        cycle(); chk("skid_pcD", o_pcD, 32'h4); chk("skid_instr", o_instr, mem(32'h4));
        cycle(); chk("after_skid", o_pcD, 32'h8);

        // redirect during a 3-cycle miss at 0x40
        lat_mode = 1;
        do_reset();
        d_rd = 1'b1; d_rpc = 32'h40;
        cycle();
        d_rpc = 32'h100;
        cycle(); chk("miss_addr", o_addr, 32'h40);
        d_rd = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("miss_hold_addr", o_addr, 32'h40);
            chk("miss_bubble", {31'b0, o_valid}, 32'd0);
        end
        cycle(); chk("redir_addr", o_addr, 32'h100); chk("redir_bubble", {31'b0, o_valid}, 32'd0);

        // BTB training at 0x20 -> 0x80
        lat_mode = 0;
        do_reset();
        d_uv = 1'b1; d_upc = 32'h20; d_utg = 32'h80; d_ut = 1'b1;
        cycle();
        d_rd = 1'b1; d_rpc = 32'h20;
        cycle();
        d_uv = 1'b0; d_rd = 1'b0;
        cycle(); chk("btb_fetch", o_addr, 32'h20);
        d_uv = 1'b1; d_ut = 1'b0; d_rd = 1'b1;
        cycle(); chk("btb_pcD", o_pcD, 32'h20); chk("btb_pred", o_pred, P80); chk("btb_next", o_addr, P80);
        d_rd = 1'b0;
        cycle(); chk("btb_refetch", o_addr, 32'h20);
        d_uv = 1'b0; d_rd = 1'b1;
        cycle(); chk("btb_pred_ctr10", o_pred, P80);
        d_rd = 1'b0;
        cycle();
        cycle(); chk("btb_pred_ctr01", o_pred, 32'h24);

        // redirect and memhazard together
        do_reset();
        cycle(); cycle();
        d_mh = 1'b1; d_rd = 1'b1; d_rpc = 32'h200;
        cycle(); chk("rm_pc0", o_pcD, 32'h0);
        d_mh = 1'b0; d_rd = 1'b0;
        cycle(); chk("rm_bubble", {31'b0, o_valid}, 32'd0); chk("rm_addr", o_addr, 32'h200);
        cycle(); chk("rm_pcD", o_pcD, 32'h200); chk("rm_instr", o_instr, mem(32'h200));

        // randomized traffic
        lat_mode = 2;
        rand_mode = 1'b1;
        repeat (4000) cycle();
        rand_mode = 1'b0;
        do_reset();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage RISC-V core. Holds the architectural PC and drives the instruction cache through a request/ready handshake. Predicts the next PC with a small direct-mapped branch target buffer (BTB) and registers the fetched instruction into the IF/ID boundary consumed by decode. Handles load-use stalls, data-cache stalls and execute-stage misprediction redirects, including a redirect that arrives while an icache access is outstanding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- hazard  in  1  load-use stall from hazard unit; hold IF/ID and PC
- memhazard  in  1  data-cache stall; hold IF/ID and PC
- redirect  in  1  misprediction from EX; flush and refetch
- redirect_pc  in  32  correct next PC when redirect=1
- upd_valid  in  1  EX resolved a control-transfer instruction this cycle
- upd_pc  in  32  PC of resolved instruction
- upd_target  in  32  resolved target
- upd_taken  in  1  resolved direction
- icache_req  out  1  fetch request
- icache_addr  out  32  fetch address (word aligned)
- icache_ready  in  1  one-cycle pulse; icache_rdata valid for icache_addr
- icache_rdata  in  32  instruction word
- pcD  out  32  PC to decode
- instrD  out  32  instruction to decode
- predictpcD  out  32  predicted next PC of instrD
- validD  out  1  instrD is a real instruction (0 = bubble)

## Operation
- FSM states: REQ, HOLD, DISCARD.
- REQ: icache_req=1, icache_addr=pc. On icache_ready:
  - not stalled (hazard|memhazard=0): IF/ID <= {pc, rdata, pred, 1}; pc <= pred; stay REQ.
  - stalled: capture {pc, rdata, pred} into a one-entry skid buffer; pc <= pred; go HOLD.
- HOLD: icache_req=0. When stall clears: IF/ID <= buffer; go REQ.
- DISCARD: icache_req=1, icache_addr = old address (unchanged). On icache_ready: drop data; go REQ at the latched redirect PC.
- Handshake: once icache_req=1, icache_addr stays stable until icache_ready. No new address issues mid-access.
- Bubble: not stalled and no instruction delivered this cycle -> IF/ID <= {pc, 32'h0000_0013, pc, 0}.
- Stall: IF/ID registers hold all values.
- redirect has highest priority, above stalls:
  - IF/ID becomes bubble; skid buffer cleared; pc <= redirect_pc.
  - From REQ with access outstanding and no icache_ready that cycle -> DISCARD.
  - From REQ with icache_ready the same cycle, or from HOLD -> REQ; returned data dropped.
  - In DISCARD, a further redirect overwrites the latched PC.
- BTB, direct mapped: index pc[log2(BTB_ENTRIES)+1:2]; entry = {valid, tag pc[31:idx_hi+1], target, 2-bit counter}.
- Prediction, combinational on pc: hit && ctr[1] -> target; else pc+4. Arithmetic is 32-bit and wraps mod 2^32.
- BTB update on upd_valid:
  - tag hit: counter saturating inc if taken, dec if not; target <= upd_target if taken.
  - miss and taken: allocate with ctr=2'b10.
  - miss and not taken: no change.
- Update and lookup of the same entry in one cycle: the lookup sees the old contents.

## Timing
- Reset values: pc=RESET_PC; state=REQ; icache_req=0 while rst=1; pcD=0; instrD=32'h0000_0013; predictpcD=0; validD=0; skid buffer empty; all BTB valid=0, counters=2'b01.
- First request: cycle after rst falls, icache_addr=RESET_PC.
- Latency: icache_ready at cycle t -> instrD/validD visible at t+1 (unstalled).
- Redirect at t, nothing outstanding: icache_addr=redirect_pc at t+1.
- Redirect at t, access outstanding: old address held until its ready pulse; redirect_pc issued the cycle after that pulse.
- Zero-wait icache (ready every cycle): one instruction per cycle.
- rst mid-access: state returns to REQ and any in-flight data is dropped; the icache is reset by the same rst.

## Configuration
- BTB_EN defined: BTB instantiated as above.
- BTB_EN undefined: no BTB storage; pred = pc+4 always; upd_* ports ignored; all other behaviour unchanged.

## Test plan
- Reset, then zero-wait icache returning sequential words -> pcD 0,4,8,12 on consecutive cycles, validD=1.
- Stall: hazard=1 for 2 cycles while ready pulses -> IF/ID holds; buffered word appears on the cycle hazard drops; no instruction lost or duplicated.
- Redirect during a 3-cycle miss to 0x40 with redirect_pc=0x100 -> icache_addr stays 0x40 until ready; data dropped; next address 0x100; validD=0 meanwhile.
- BTB training: upd pc=0x20, target=0x80, taken, twice -> next fetch at 0x20 gives predictpcD=0x80 and next address 0x80. One not-taken update -> still 0x80 (ctr 11->10); a second -> 0x24.
- Redirect and memhazard in the same cycle -> redirect wins; bubble inserted; fetch from redirect_pc.
- BTB_EN undefined: repeat the training test -> predictpcD=0x24.
